cache_miss_handler: RTL and testbench

- Sits directly downstream of the 4-way tag comparator.
- Accepts one lookup result per request: address, hit flag and hit way.
- On a hit, updates true-LRU state. On a miss, picks a victim way, writes it back if dirty, fills the line from memory, then rewrites the tag-directory row.
- Sole writer of tag directory, data array and LRU state.

---
 rtl/cache_miss_handler.sv | 218 +++++++++++++++++++++
 tb/tb_cache_miss_handler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_handler.sv
// Hit/miss handler behind the 4-way tag comparator: true-LRU update,
// victim writeback and line fill, then tag-directory row rewrite.
module cache_miss_handler #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int SET_W    = 4,
    parameter int TAG_W    = 10,
    parameter int WAYS     = 4,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic                         req_write,
    input  logic                         req_hit,
    input  logic [1:0]                   req_hit_way,
    input  logic [WAYS-1:0]              set_valid,
    input  logic [WAYS-1:0]              set_dirty,
    input  logic [WAYS*TAG_W-1:0]        set_tags,
    output logic                         done,
    output logic                         td_we,
    output logic [SET_W+1:0]             td_row,
    output logic [TAG_W-1:0]             td_tag,
    output logic                         td_valid,
    output logic                         td_dirty,
    output logic                         da_we,
    output logic [SET_W+OFFSET_W+1:0]    da_addr,
    output logic [DATA_W-1:0]            da_wdata,
    input  logic [DATA_W-1:0]            da_rdata,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata
);
    localparam int WAY_W = 2;
    localparam int SETS  = 1 << SET_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

    typedef enum logic [2:0] {
        IDLE, HIT_UPD, WB_RD, WB_WR, FILL, TAG_WR, DONE
    } state_t;

    state_t state_q, state_d;

    logic [SET_W-1:0]    req_set, set_q;
    logic [TAG_W-1:0]    req_tag_q, tag_q;
    logic                write_q;
    logic [WAY_W-1:0]    hit_way_q, victim_q, victim, upd_way;
    logic [OFFSET_W-1:0] word_q;
    logic                cap_q, gap_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [TAG_W-1:0]    tag_arr [WAYS];
    logic [SETS-1:0][WAYS-1:0][1:0] lru_q;
    logic                accept, ack;

    assign req_set   = req_addr[OFFSET_W +: SET_W];
    assign accept    = req_valid && (state_q == IDLE);
    assign ack       = mem_req && mem_ack;
    assign mem_wdata = wdata_q;
    assign upd_way   = (state_q == HIT_UPD) ? hit_way_q : victim_q;

    always_comb begin
        for (int w = 0; w < WAYS; w++)
            tag_arr[w] = set_tags[w*TAG_W +: TAG_W];
    end

    // Any invalid way beats the LRU way; lowest index wins among them.
    always_comb begin
        victim = '0;
        for (int w = WAYS-1; w >= 0; w--)
            if (lru_q[req_set][w] == 2'd3) victim = WAY_W'(w);
        for (int w = WAYS-1; w >= 0; w--)
            if (!set_valid[w]) victim = WAY_W'(w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        done      = 1'b0;
        td_we     = 1'b0;
        td_row    = '0;
        td_tag    = '0;
        td_valid  = 1'b0;
        td_dirty  = 1'b0;
        da_we     = 1'b0;
        da_addr   = '0;
        da_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_hit)
                        state_d = HIT_UPD;
                    else if (set_valid[victim] && set_dirty[victim])
                        state_d = WB_RD;
                    else
                        state_d = FILL;
                end
            end
            HIT_UPD: begin
                td_we    = write_q;
                td_row   = write_q ? {set_q, hit_way_q} : '0;
                td_tag   = write_q ? tag_q : '0;
                td_valid = write_q;
                td_dirty = write_q;
                state_d  = DONE;
            end
            WB_RD: begin
                da_addr = {set_q, victim_q, word_q};
                state_d = WB_WR;
            end
            // First cycle captures the array word; the request follows.
            WB_WR: begin
                mem_we   = 1'b1;
                mem_addr = {tag_q, set_q, word_q};
                if (cap_q) begin
                    mem_req = 1'b1;
                    if (mem_ack)
                        state_d = (word_q == LAST_WORD) ? FILL : WB_RD;
                end
            end
            FILL: begin
                mem_addr = {req_tag_q, set_q, word_q};
                if (!cap_q && !gap_q) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        da_we    = 1'b1;
                        da_addr  = {set_q, victim_q, word_q};
                        da_wdata = mem_rdata;
                    end
                end else if (cap_q && word_q == LAST_WORD) begin
                    state_d = TAG_WR;
                end
            end
            TAG_WR: begin
                td_we    = 1'b1;
                td_row   = {set_q, victim_q};
                td_tag   = req_tag_q;
                td_valid = 1'b1;
                td_dirty = write_q;
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q     <= '0;
            req_tag_q <= '0;
            tag_q     <= '0;
            write_q   <= 1'b0;
            hit_way_q <= '0;
            victim_q  <= '0;
            word_q    <= '0;
            cap_q     <= 1'b0;
            gap_q     <= 1'b0;
            wdata_q   <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    lru_q[s][w] <= WAY_W'(w);
        end else begin
            gap_q <= ack;
            if (accept) begin
                set_q     <= req_set;
                req_tag_q <= req_addr[ADDR_W-1 -: TAG_W];
                tag_q     <= req_hit ? tag_arr[req_hit_way] : tag_arr[victim];
                write_q   <= req_write;
                hit_way_q <= req_hit_way;
                victim_q  <= victim;
                word_q    <= '0;
                cap_q     <= 1'b0;
            end
            if (state_q == WB_WR) begin
                if (!cap_q) begin
                    wdata_q <= da_rdata;
                    cap_q   <= 1'b1;
                end else if (ack) begin
                    cap_q  <= 1'b0;
                    word_q <= word_q + 1'b1;
                end
            end
            // A fill beat ends with one idle cycle before the next request.
            if (state_q == FILL) begin
                if (cap_q) begin
                    cap_q  <= 1'b0;
                    word_q <= word_q + 1'b1;
                end else if (ack) begin
                    cap_q <= 1'b1;
                end
            end
            if (state_q == HIT_UPD || state_q == TAG_WR) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (WAY_W'(v) == upd_way)
                        lru_q[set_q][v] <= 2'd0;
                    else if (lru_q[set_q][v] < lru_q[set_q][upd_way])
                        lru_q[set_q][v] <= lru_q[set_q][v] + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: memory/data-array models,
// bus monitor and hand-computed expectations.
module tb_cache_miss_handler;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, req_hit;
    logic [15:0] req_addr;
    logic [1:0]  req_hit_way;
    logic [3:0]  set_valid, set_dirty;
    logic [39:0] set_tags;
    logic        done, td_we, td_valid, td_dirty, da_we;
    logic [5:0]  td_row;
    logic [9:0]  td_tag;
    logic [7:0]  da_addr, da_wdata, da_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    cache_miss_handler dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .req_hit(req_hit), .req_hit_way(req_hit_way),
        .set_valid(set_valid), .set_dirty(set_dirty),
        .set_tags(set_tags), .done(done),
        .td_we(td_we), .td_row(td_row), .td_tag(td_tag),
        .td_valid(td_valid), .td_dirty(td_dirty),
        .da_we(da_we), .da_addr(da_addr),
        .da_wdata(da_wdata), .da_rdata(da_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_chk, n_pass, cyc, ack_delay;
    int td_cnt, da_cnt, mreq_cnt, done_cnt, done_cyc;
    int stab_err, gap_err, log_n;
    int td_base, da_base, mreq_base, log_base, stab_base;
    logic [5:0]  td_row_s;
    logic [9:0]  td_tag_s;
    logic        td_valid_s, td_dirty_s;
    logic [7:0]  bdata [256];
    logic [7:0]  last_da;
    logic        log_we [64];
    logic [15:0] log_addr [64];
    logic [7:0]  log_wd [64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory and data-array read models (1-cycle array latency).
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        da_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            da_rdata = bdata[last_da];
            if (mem_req && wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr[7:0] ^ 8'h5A;
                wait_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = mem_req ? wait_cnt + 1 : 0;
            end
        end
    end

    // Bus monitor: array image, counters, transaction log, handshake rules.
    initial begin
        logic        pend, acked, p_we;
        logic [15:0] p_addr;
        logic [7:0]  p_wd;
        pend = 1'b0; acked = 1'b0; p_we = 1'b0;
        p_addr = '0; p_wd = '0; last_da = '0;
        td_cnt = 0; da_cnt = 0; mreq_cnt = 0; done_cnt = 0;
        done_cyc = 0; stab_err = 0; gap_err = 0; log_n = 0;
        td_row_s = '0; td_tag_s = '0; td_valid_s = 0; td_dirty_s = 0;
        for (int i = 0; i < 256; i++) bdata[i] = 8'(i) ^ 8'hC3;
        forever begin
            @(negedge clk);
            last_da = da_addr;
            if (rst_n) begin
                if (td_we) begin
                    td_cnt++;
                    td_row_s = td_row; td_tag_s = td_tag;
                    td_valid_s = td_valid; td_dirty_s = td_dirty;
                end
                if (da_we) begin
                    da_cnt++;
                    bdata[da_addr] = da_wdata;
                end
                if (mem_req) mreq_cnt++;
                if (pend && (!mem_req || mem_addr != p_addr ||
                             mem_we != p_we || mem_wdata != p_wd))
                    stab_err++;
                if (acked && mem_req) gap_err++;
                if (mem_req && mem_ack && log_n < 64) begin
                    log_we[log_n]   = mem_we;
                    log_addr[log_n] = mem_addr;
                    log_wd[log_n]   = mem_wdata;
                    log_n++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                pend   = mem_req && !mem_ack;
                acked  = mem_req && mem_ack;
                p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
            end else begin
                pend = 1'b0;
                acked = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [15:0] a, input logic w, h,
                             input logic [1:0] hw, input logic [3:0] v, d,
                             input logic [39:0] t, output int acc);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready", req_ready, 1);
        req_addr = a; req_write = w; req_hit = h; req_hit_way = hw;
        set_valid = v; set_dirty = d; set_tags = t;
        req_valid = 1'b1;
        acc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run(input logic [15:0] a, input logic w, h,
                       input logic [1:0] hw, input logic [3:0] v, d,
                       input logic [39:0] t, output int lat);
        int acc, d0, n;
        td_base = td_cnt; da_base = da_cnt; mreq_base = mreq_cnt;
        log_base = log_n; stab_base = stab_err; d0 = done_cnt;
        start_req(a, w, h, hw, v, d, t, acc);
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            tick();
            n++;
        end
        check("done", done_cnt - d0, 1);
        lat = done_cyc - acc;
    endtask

    initial begin
        int lat, acc, n;
        n_chk = 0; n_pass = 0; ack_delay = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_hit = 1'b0; req_hit_way = '0; set_valid = '0; set_dirty = '0;
        set_tags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_td_we", td_we, 0);
        check("rst_da_we", da_we, 0);
        rst_n = 1'b1;
        tick();

        // Cold miss, set 13, all ways invalid -> way0.
        run(16'h1234, 0, 0, 2'd0, 4'h0, 4'h0, 40'h0, lat);
        check("t1_lat", lat, 10);
        check("t1_td_n", td_cnt - td_base, 1);
        check("t1_row", td_row_s, 6'h34);
        check("t1_tag", td_tag_s, 10'h048);
        check("t1_valid", td_valid_s, 1);
        check("t1_dirty", td_dirty_s, 0);
        check("t1_beats", log_n - log_base, 4);
        check("t1_da_n", da_cnt - da_base, 4);
        for (int k = 0; k < 4; k++) begin
            check("t1_rd_we", log_we[log_base+k], 0);
            check("t1_rd_addr", log_addr[log_base+k], 16'h1234 + 16'(k));
            check("t1_line", bdata[8'hD0 + 8'(k)], (8'h34 + 8'(k)) ^ 8'h5A);
        end

        // Set 5: store hit way2, load hit way3, then two LRU victims.
        run(16'h2AD4, 1, 1, 2'd2, 4'hF, 4'h0,
            {10'h3, 10'h0AB, 10'h2, 10'h1}, lat);
        check("t2_hit_lat", lat, 2);
        check("t2_hit_mreq", mreq_cnt - mreq_base, 0);
        check("t2_hit_td_n", td_cnt - td_base, 1);
        check("t2_hit_row", td_row_s, 6'h16);
        check("t2_hit_tag", td_tag_s, 10'h0AB);
        check("t2_hit_valid", td_valid_s, 1);
        check("t2_hit_dirty", td_dirty_s, 1);
        run(16'h2AD4, 0, 1, 2'd3, 4'hF, 4'h0,
            {10'h2AB, 10'h0AB, 10'h2, 10'h1}, lat);
        check("t2_ld_lat", lat, 2);
        check("t2_ld_td_n", td_cnt - td_base, 0);
        run(16'h0154, 0, 0, 2'd0, 4'hF, 4'h0,
            {10'h2AB, 10'h0AB, 10'h2, 10'h1}, lat);
        check("t2_v1_row", td_row_s, 6'h15);
        check("t2_v1_beats", log_n - log_base, 4);
        check("t2_v1_we", log_we[log_base], 0);
        run(16'h0194, 0, 0, 2'd0, 4'hF, 4'h0,
            {10'h2AB, 10'h0AB, 10'h005, 10'h1}, lat);
        check("t2_v0_row", td_row_s, 6'h14);

        // Set 3 all valid/clean, reset ages -> way3, fill only.
        run(16'h400C, 0, 0, 2'd0, 4'hF, 4'h0,
            {10'h4, 10'h3, 10'h2, 10'h1}, lat);
        check("t3_lat", lat, 10);
        check("t3_row", td_row_s, 6'h0F);
        check("t3_beats", log_n - log_base, 4);
        check("t3_dirty", td_dirty_s, 0);

        // Hit way2 leaves way1 oldest; store miss writes back dirty way1.
        run(16'h400C, 0, 1, 2'd2, 4'hF, 4'h0,
            {10'h100, 10'h3, 10'h2, 10'h1}, lat);
        check("t4_prep_lat", lat, 2);
        run(16'h3C0C, 1, 0, 2'd0, 4'hF, 4'b0010,
            {10'h100, 10'h3, 10'h2AA, 10'h1}, lat);
        check("t4_row", td_row_s, 6'h0D);
        check("t4_tag", td_tag_s, 10'h0F0);
        check("t4_dirty", td_dirty_s, 1);
        check("t4_beats", log_n - log_base, 8);
        for (int k = 0; k < 4; k++) begin
            check("t4_wb_we", log_we[log_base+k], 1);
            check("t4_wb_addr", log_addr[log_base+k], 16'hAA8C + 16'(k));
            check("t4_wb_data", log_wd[log_base+k], (8'h34 + 8'(k)) ^ 8'hC3);
            check("t4_fill_we", log_we[log_base+4+k], 0);
            check("t4_fill_addr", log_addr[log_base+4+k], 16'h3C0C + 16'(k));
        end

        // Slow memory: every beat acked 5 cycles late.
        ack_delay = 5;
        run(16'h004C, 0, 0, 2'd0, 4'hF, 4'b0001,
            {10'h1, 10'h2, 10'h3, 10'h155}, lat);
        ack_delay = 0;
        check("t5_stable", stab_err - stab_base, 0);
        check("t5_da_n", da_cnt - da_base, 4);
        check("t5_beats", log_n - log_base, 8);
        check("t5_wb_addr", log_addr[log_base], 16'h554C);
        check("t5_wb_data", log_wd[log_base], 8'hF3);
        check("t5_fill_addr", log_addr[log_base+4], 16'h004C);
        check("t5_fill_we", log_we[log_base+4], 0);
        check("t5_row", td_row_s, 6'h0C);
        check("t5_mreq_min", (mreq_cnt - mreq_base) >= 48, 1);

        // Reset while fill beat 2 is on the bus.
        td_base = td_cnt;
        start_req(16'hFFE4, 0, 0, 2'd0, 4'h0, 4'h0, 40'h0, acc);
        n = 0;
        while (!(mem_req && mem_addr == 16'hFFE6) && n < 100) begin
            tick();
            n++;
        end
        check("t6_beat2", mem_addr, 16'hFFE6);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", req_ready, 1);
        check("t6_rst_mem_req", mem_req, 0);
        check("t6_rst_da_we", da_we, 0);
        check("t6_rst_td_we", td_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_no_td", td_cnt - td_base, 0);
        tick();
        run(16'hFFE4, 0, 0, 2'd0, 4'h0, 4'h0, 40'h0, lat);
        check("t6_row", td_row_s, 6'h24);
        check("t6_valid", td_valid_s, 1);
        check("t6_beats", log_n - log_base, 4);
        run(16'h01D4, 0, 0, 2'd0, 4'hF, 4'h0,
            {10'h3, 10'h2, 10'h1, 10'h0}, lat);
        check("t6_lru_reset_row", td_row_s, 6'h17);

        check("gap_total", gap_err, 0);
        check("stable_total", stab_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
